fib_sched: RTL and testbench

FIB_SCHED -- requirements
Module: fib_sched

---
 rtl/fib_pkg.sv | 9 +
 rtl/fib_sched_if.sv | 19 +
 rtl/fib_sched_rr_arb2.sv | 13 +
 rtl/fib_sched.sv | 71 +++++++
 tb/tb_fib_sched.sv | 133 +++++++++++++
 5 files changed

// File: rtl/fib_pkg.sv
// fib_pkg: shared state encoding and default sizes for the Fibonacci scheduler
//   FIB_WIDTH : default result/accumulator width
//   FIB_NW    : default width of a requested index
//   state_t   : scheduler FSM states
package fib_pkg;
   localparam int FIB_WIDTH = 16;
   localparam int FIB_NW    = 4;
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_DONE} state_t;
endpackage

// File: rtl/fib_sched_if.sv
// fib_sched_if: request/grant/result bundle between two requesters and the scheduler
//   req[1:0]  : per-requester request
//   n0, n1    : index requested by requester 0 / 1
//   gnt[1:0]  : one-hot owner grant
//   done[1:0] : one-cycle completion pulse on the owner's bit
//   result    : Fibonacci value of the last completed job
//   busy      : scheduler not idle
import fib_pkg::*;
interface fib_sched_if #(parameter int WIDTH = FIB_WIDTH, parameter int NW = FIB_NW);
   logic [1:0]       req;
   logic [NW-1:0]    n0;
   logic [NW-1:0]    n1;
   logic [1:0]       gnt;
   logic [1:0]       done;
   logic [WIDTH-1:0] result;
   logic             busy;
   modport master (output req, n0, n1, input gnt, done, result, busy);
   modport slave  (input req, n0, n1, output gnt, done, result, busy);
endinterface

// File: rtl/fib_sched_rr_arb2.sv
// rr_arb2: two-way round-robin pick
//   req[1:0]   : active requests
//   last_owner : index of the requester served most recently
//   pick[1:0]  : one-hot winner, zero when nothing is requested
import fib_pkg::*;
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic [1:0] pick
);
   // on contention the requester that did not go last wins
   assign pick = &req ? (last_owner ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/fib_sched.sv
// fib_sched: arbitrates two requesters and computes F(n) iteratively for the winner
//   clk       : clock, rising edge
//   rst       : synchronous reset, active low
//   bus       : fib_sched_if slave (req, n0, n1 in; gnt, done, result, busy out)
import fib_pkg::*;
module fib_sched #(
   parameter int WIDTH = FIB_WIDTH,
   parameter int NW    = FIB_NW
) (
   input  logic      clk,
   input  logic      rst,
   fib_sched_if.slave bus
);
   state_t           state;
   state_t           state_nx;
   logic [1:0]       pick;
   logic [1:0]       owner;
   logic             last_owner;
   logic [NW-1:0]    n_reg;
   logic [NW-1:0]    k;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] result;
   rr_arb2 u_arb (.req(bus.req), .last_owner(last_owner), .pick(pick));
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: state_nx = |bus.req ? S_LOAD : S_IDLE;
         S_LOAD: state_nx = S_CALC;
         S_CALC: state_nx = k == n_reg ? S_DONE : S_CALC;
         S_DONE: state_nx = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         owner      <= '0;
         last_owner <= 1'b1;
         n_reg      <= '0;
         k          <= '0;
         a          <= '0;
         b          <= '0;
         result     <= '0;
      end else begin
         state <= state_nx;
         unique case (state)
            S_IDLE: owner <= pick;
            S_LOAD: begin
               n_reg <= owner[1] ? bus.n1 : bus.n0;
               a     <= '0;
               b     <= WIDTH'(1);
               k     <= '0;
            end
            S_CALC: if (k != n_reg) begin
               a <= b;
               b <= a + b;
               k <= k + 1'b1;
            end
            S_DONE: begin
               result     <= a;
               last_owner <= owner[1];
            end
         endcase
      end
   end
   // owner is only meaningful once a job has been accepted
   assign bus.gnt    = state == S_IDLE ? 2'b00 : owner;
   assign bus.done   = state == S_DONE ? owner : 2'b00;
   assign bus.busy   = state != S_IDLE;
   assign bus.result = result;
endmodule

// File: tb/tb_fib_sched.sv
// tb_fib_sched: table-driven, hand-sequenced and randomized checks of fib_sched
import fib_pkg::*;
module tb_fib_sched;
   typedef struct {
      logic [1:0] req;
      logic [3:0] n0;
      logic [3:0] n1;
      int         mode;
      logic [1:0] g;
      int         f;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   ncmp = 0;
   int   nfail = 0;
   logic last_m = 1'b1;
   vec_t tv[$];
   fib_sched_if #(.WIDTH(16), .NW(4)) bus();
   fib_sched dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      ncmp++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   function automatic int fib(input int n);
      int x = 0;
      int y = 1;
      int t;
      for (int i = 0; i < n; i++) begin
         t = (x + y) & 32'hffff;
         x = y;
         y = t;
      end
      return x;
   endfunction
   // starts in an IDLE cycle; mode 0 holds inputs, 1 drops req and flips n, 2 randomizes both
   task automatic do_job(input logic [1:0] r, input logic [3:0] x0, input logic [3:0] x1,
                         input int mode, input logic [1:0] g, input int f);
      int n;
      n = g[1] ? int'(x1) : int'(x0);
      bus.req = r;
      bus.n0  = x0;
      bus.n1  = x1;
      for (int j = 1; j <= n + 3; j++) begin
         @(posedge clk); #1;
         chk("gnt", int'(bus.gnt), int'(g));
         chk("done", int'(bus.done), j == n + 3 ? int'(g) : 0);
         chk("busy", int'(bus.busy), 1);
         if (j >= 2 && j <= n + 2 && mode == 1) begin
            bus.req = 2'b00;
            bus.n0  = ~x0;
            bus.n1  = ~x1;
         end
         if (j >= 2 && j <= n + 2 && mode == 2) begin
            bus.req = 2'($urandom_range(0, 3));
            bus.n0  = 4'($urandom);
            bus.n1  = 4'($urandom);
         end
      end
      @(posedge clk); #1;
      chk("result", int'(bus.result), f);
      chk("idle_busy", int'(bus.busy), 0);
      chk("idle_gnt", int'(bus.gnt), 0);
      chk("idle_done", int'(bus.done), 0);
      last_m = g[1];
   endtask
   initial begin
      int seen;
      logic [1:0] r;
      logic [3:0] x0;
      logic [3:0] x1;
      logic w;
      tv.push_back('{2'b01, 4'd10, 4'd0,  0, 2'b01, 55});
      tv.push_back('{2'b10, 4'd0,  4'd0,  0, 2'b10, 0});
      tv.push_back('{2'b10, 4'd0,  4'd1,  0, 2'b10, 1});
      tv.push_back('{2'b11, 4'd5,  4'd7,  0, 2'b01, 5});
      tv.push_back('{2'b11, 4'd5,  4'd7,  0, 2'b10, 13});
      tv.push_back('{2'b01, 4'd15, 4'd3,  0, 2'b01, 610});
      tv.push_back('{2'b10, 4'd0,  4'd12, 0, 2'b10, 144});
      tv.push_back('{2'b11, 4'd2,  4'd9,  0, 2'b01, 1});
      tv.push_back('{2'b11, 4'd3,  4'd9,  0, 2'b10, 34});
      tv.push_back('{2'b01, 4'd8,  4'd0,  1, 2'b01, 21});
      tv.push_back('{2'b10, 4'd3,  4'd6,  1, 2'b10, 8});
      tv.push_back('{2'b11, 4'd4,  4'd4,  1, 2'b01, 3});
      bus.req = 2'b00;
      bus.n0  = '0;
      bus.n1  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", int'(bus.gnt), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_result", int'(bus.result), 0);
      rst = 1'b1;
      @(posedge clk); #1;
      foreach (tv[i]) do_job(tv[i].req, tv[i].n0, tv[i].n1, tv[i].mode, tv[i].g, tv[i].f);
      // reset in the middle of a long job
      bus.req = 2'b01;
      bus.n0  = 4'd15;
      repeat (6) @(posedge clk);
      #1;
      chk("mid_gnt", int'(bus.gnt), 1);
      chk("mid_busy", int'(bus.busy), 1);
      rst = 1'b0;
      bus.req = 2'b00;
      @(posedge clk); #1;
      chk("abort_gnt", int'(bus.gnt), 0);
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_result", int'(bus.result), 0);
      chk("abort_done", int'(bus.done), 0);
      rst = 1'b1;
      last_m = 1'b1;
      seen = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (bus.done != 2'b00) seen++;
      end
      chk("abort_no_done", seen, 0);
      for (int i = 0; i < 30; i++) begin
         r  = 2'($urandom_range(1, 3));
         x0 = 4'($urandom);
         x1 = 4'($urandom);
         w  = r == 2'b11 ? ~last_m : r[1];
         do_job(r, x0, x1, 2, w ? 2'b10 : 2'b01, fib(w ? int'(x1) : int'(x0)));
      end
      bus.req = 2'b00;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
